crypt_engine: RTL and testbench
===============================

Name: crypt_engine

Overview:
- Byte-stream encrypt/decrypt datapath. Sits directly downstream of the configuration register and consumes its 32-bit output as the mode/key word.
- Transforms a valid/ready byte stream with an LFSR keystream XOR plus a bit rotation.
- Accepts data only in run mode (cfg[0]=1). Config mode (cfg[0]=0) idles the engine.

Parameters:
- CNT_W, 16, width of the processed-byte counter.
- LFSR_MASK, 24'hE10000, Galois feedback mask (taps 24,23,22,17; maximal length).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- cfg  input  32  config word: [0] run_en, [1] dir (0=encrypt, 1=decrypt), [4:2] rot, [7:5] reserved/ignored, [31:8] seed.
- in_valid  input  1  input byte valid.
- in_data  input  8  input byte.
- in_ready  output  1  engine accepts a byte this cycle.
- out_valid  output  1  output byte valid.
- out_data  output  8  transformed byte.
- out_ready  input  1  downstream accepts the output byte.
- busy  output  1  high in LOAD, RUN or DRAIN.
- byte_count  output  CNT_W  bytes accepted since last LOAD.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, byte_count=0, lfsr=24'h000001, state=IDLE.
- IDLE:
  - If cfg[0]=1, go to LOAD.
  - in_ready=0.
- LOAD (1 cycle):
  - lfsr <= cfg[31:8], or 24'h000001 if the seed is zero.
  - byte_count <= 0.
  - Latch dir_q=cfg[1] and rot_q=cfg[4:2]. The latched values are used for the whole run.
  - Go to RUN.
  - in_ready=0.
- RUN:
  - in_ready = !out_valid || out_ready.
  - A byte is accepted when in_valid && in_ready.
  - If cfg[0] falls to 0, go to DRAIN that cycle. No byte is accepted in that cycle (in_ready is gated by cfg[0]).
- DRAIN:
  - in_ready=0.
  - Hold the pending output until out_valid && out_ready, or go immediately if none is pending. Then go to IDLE.
  - A re-asserted cfg[0] during DRAIN does not take effect until IDLE; the next cycle then enters LOAD.
- Transform on accept:
  - ks = lfsr[7:0], using the value before advancing.
  - Encrypt: out = rotl8(in ^ ks, rot_q).
  - Decrypt: out = rotr8(in, rot_q) ^ ks.
  - rot_q=0 means no rotation.
- LFSR advance: one step per accepted byte only. lfsr <= lfsr[0] ? (lfsr>>1) ^ LFSR_MASK : lfsr>>1. No advance on stall.
- Latency: 1 cycle. out_data/out_valid are registered the cycle after acceptance. Full throughput (1 byte/cycle) when out_ready=1.
- Output register:
  - out_valid set on accept.
  - out_valid cleared on out_ready with no new accept.
  - Simultaneous out_ready and new accept: out_valid stays 1 and out_data is replaced.
  - out_data is stable while out_valid && !out_ready.
- byte_count:
  - Increments per accept.
  - Wraps to 0 after 2^CNT_W-1.
  - Holds its value in IDLE until the next LOAD.
- cfg changes to dir/rot/seed while in RUN are ignored. They require cfg[0] to go 0 and then back to 1.
- Asynchronous reset mid-operation drops any pending output immediately (out_valid=0) and returns to IDLE.

Decomposition:
- Shared package crypt_pkg holds:
  - state enum {IDLE, LOAD, RUN, DRAIN}.
  - cfg bit-position constants CFG_RUN=0, CFG_DIR=1, CFG_ROT_LSB=2, CFG_ROT_MSB=4, CFG_SEED_LSB=8.
  - LFSR default mask and reset-seed constants.
  - rotl8/rotr8 functions.
- One sub-module is natural: keystream_lfsr (load, advance, seed in; 24-bit state out).

Test Plan:
- Reset: assert rst=0 mid-stream with out_valid=1 -> out_valid=0, in_ready=0, busy=0, byte_count=0 immediately.
- Encrypt, cfg=32'h0000FF01 (seed FF, rot 0): bytes 0x0F then 0x00 -> out 0xF0 then 0x7F (lfsr after step 1 = 0xE1007F); byte_count=2.
- Encrypt with rotation, cfg=32'h0000FF11 (rot 4): in 0x0F -> out 0x0F. Decrypt, cfg=32'h0000FF13: in 0x0F -> out 0x0F. Both confirm the round trip.
- Zero seed, cfg=32'h00000001: in 0x00 -> out 0x01; next in 0xA5 -> out 0xA5 (lfsr=0xE10000).
- Backpressure: hold out_ready=0 for 5 cycles after the first accept -> in_ready=0, out_data stable, LFSR not advanced; release -> stream resumes with no loss or duplication.
- Mode drop: clear cfg[0] with output pending and out_ready=0 -> DRAIN, in_ready=0, busy=1; assert out_ready -> byte delivered, IDLE next cycle, busy=0.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared definitions for the byte-stream crypt engine: FSM states, config
// word field positions, LFSR constants and byte rotation helpers.
package crypt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int CFG_RUN      = 0;
    localparam int CFG_DIR      = 1;
    localparam int CFG_ROT_LSB  = 2;
    localparam int CFG_ROT_MSB  = 4;
    localparam int CFG_SEED_LSB = 8;

    localparam logic [23:0] LFSR_MASK_DEFAULT = 24'hE10000;
    localparam logic [23:0] LFSR_SEED_RST     = 24'h000001;

    function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] r);
        logic [15:0] t;
        t = {d, d} << r;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] d, input logic [2:0] r);
        logic [15:0] t;
        t = {d, d} >> r;
        return t[7:0];
    endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 24-bit Galois LFSR keystream source; loads a seed (zero seed is forced to
// the reset seed, since an all-zero Galois LFSR never leaves zero).
module keystream_lfsr
    import crypt_pkg::*;
#(
    parameter logic [23:0] LFSR_MASK = LFSR_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [23:0] seed,
    output logic [23:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_SEED_RST;
        end else if (load) begin
            state <= (seed == 24'd0) ? LFSR_SEED_RST : seed;
        end else if (advance) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_MASK) : (state >> 1);
        end
    end

endmodule

// File: rtl/crypt_engine.sv
// Byte-stream encrypt/decrypt engine: LFSR keystream XOR plus rotation,
// valid/ready in and out with a single registered output stage.
module crypt_engine
    import crypt_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [23:0] LFSR_MASK = LFSR_MASK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cfg,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);

    state_t      state, state_nxt;
    logic        dir_q;
    logic [2:0]  rot_q;
    logic [23:0] lfsr;
    logic        load;
    logic        accept;
    logic [7:0]  ks;
    logic [7:0]  xformed;
    logic        unused_cfg;

    assign unused_cfg = ^cfg[7:5];

    keystream_lfsr #(.LFSR_MASK(LFSR_MASK)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (accept),
        .seed    (cfg[31:CFG_SEED_LSB]),
        .state   (lfsr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: if (cfg[CFG_RUN]) state_nxt = LOAD;
            LOAD: begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                // Dropping run_en blocks acceptance in the same cycle.
                in_ready = cfg[CFG_RUN] && (!out_valid || out_ready);
                if (!cfg[CFG_RUN]) state_nxt = DRAIN;
            end
            DRAIN: if (!out_valid || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);
    assign ks     = lfsr[7:0];

    always_comb begin
        if (dir_q) xformed = rotr8(in_data, rot_q) ^ ks;
        else       xformed = rotl8(in_data ^ ks, rot_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q      <= 1'b0;
            rot_q      <= 3'd0;
            byte_count <= '0;
        end else if (load) begin
            dir_q      <= cfg[CFG_DIR];
            rot_q      <= cfg[CFG_ROT_MSB:CFG_ROT_LSB];
            byte_count <= '0;
        end else if (accept) begin
            byte_count <= byte_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= xformed;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crypt_engine.sv
// Directed-vector bench for crypt_engine with hand-computed expected bytes.
module tb_crypt_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic [15:0] byte_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    crypt_engine #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .byte_count (byte_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte, wait (bounded) for acceptance; returns just after the
    // accepting edge so the registered output can be checked.
    task automatic send_byte(input string tag, input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] c);
        cfg = c;
        tick();
        tick();
    endtask

    task automatic stop_run(input string tag);
        int n;
        cfg[0] = 1'b0;
        n = 0;
        tick();
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        cfg       = 32'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        tick();
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},  32'd0);
        chk("rst_busy",       {31'd0, busy},      32'd0);
        chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
        chk("rst_out_data",   {24'd0, out_data},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Encrypt, seed FF, no rotation
        start_run(32'h0000FF01);
        chk("enc_busy", {31'd0, busy}, 32'd1);
        send_byte("enc0", 8'h0F);
        chk("enc0_valid", {31'd0, out_valid}, 32'd1);
        chk("enc0_data", {24'd0, out_data}, 32'hF0);
        send_byte("enc1", 8'h00);
        chk("enc1_data", {24'd0, out_data}, 32'h7F);
        chk("enc_count", {16'd0, byte_count}, 32'd2);
        stop_run("enc");
        chk("idle_count_hold", {16'd0, byte_count}, 32'd2);

        // Rotation round trip
        start_run(32'h0000FF11);
        send_byte("rot_enc", 8'h0F);
        chk("rot_enc_data", {24'd0, out_data}, 32'h0F);
        stop_run("rot_enc");
        start_run(32'h0000FF13);
        send_byte("rot_dec", 8'h0F);
        chk("rot_dec_data", {24'd0, out_data}, 32'h0F);
        stop_run("rot_dec");

        // Zero seed falls back to 1
        start_run(32'h00000001);
        chk("zs_count_cleared", {16'd0, byte_count}, 32'd0);
        send_byte("zs0", 8'h00);
        chk("zs0_data", {24'd0, out_data}, 32'h01);
        send_byte("zs1", 8'hA5);
        chk("zs1_data", {24'd0, out_data}, 32'hA5);
        stop_run("zs");

        // Backpressure: stall 5 cycles, keystream must not advance
        start_run(32'h0000FF01);
        send_byte("bp0", 8'h0F);
        chk("bp0_data", {24'd0, out_data}, 32'hF0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data",  {24'd0, out_data},  32'hF0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
        end
        chk("bp_hold_count", {16'd0, byte_count}, 32'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp1_data",  {24'd0, out_data},   32'h7F);
        chk("bp1_valid", {31'd0, out_valid},  32'd1);
        chk("bp1_count", {16'd0, byte_count}, 32'd2);
        tick();
        chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
        stop_run("bp");

        // Mode drop with output pending
        start_run(32'h0000FF01);
        out_ready = 1'b0;
        send_byte("md0", 8'h0F);
        in_valid = 1'b1;
        in_data  = 8'h33;
        cfg[0]   = 1'b0;
        #1;
        chk("md_gated_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("md_drain_busy",  {31'd0, busy},      32'd1);
        chk("md_drain_ready", {31'd0, in_ready},  32'd0);
        chk("md_drain_valid", {31'd0, out_valid}, 32'd1);
        chk("md_drain_data",  {24'd0, out_data},  32'hF0);
        tick();
        chk("md_drain_hold",  {31'd0, busy},      32'd1);
        chk("md_count",       {16'd0, byte_count}, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("md_delivered", {31'd0, out_valid}, 32'd0);
        chk("md_idle_busy", {31'd0, busy},      32'd0);

        // Asynchronous reset mid-stream with output pending
        start_run(32'h0000FF01);
        out_ready = 1'b0;
        send_byte("ar0", 8'h0F);
        chk("ar_pending", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid},  32'd0);
        chk("ar_in_ready",  {31'd0, in_ready},   32'd0);
        chk("ar_busy",      {31'd0, busy},       32'd0);
        chk("ar_count",     {16'd0, byte_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
